// File: rtl/cmd_resp_ctrl.sv
// SD command-line response sequencer: waits for the card's start bit, frames the
// response for the deserializer, runs CRC7 and end-bit checks, and reports status.
module cmd_resp_ctrl #(
    parameter int TIMEOUT    = 64,
    parameter int SHORT_BITS = 48,
    parameter int LONG_BITS  = 136
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 long_resp,
    input  logic                 crc_check_en,
    input  logic                 abort,
    input  logic                 cmd_in,
    input  logic                 des_complete,
    input  logic [LONG_BITS-1:0] des_out,
    output logic                 des_enable,
    output logic [7:0]           des_framesize,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [LONG_BITS-1:0] resp_data,
    output logic                 timeout_err,
    output logic                 crc_err,
    output logic                 end_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        RECEIVE,
        CHECK,
        DONE
    } state_t;

    localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] SHORT_LEN   = 8'(SHORT_BITS);
    localparam logic [7:0] LONG_LEN    = 8'(LONG_BITS);
    localparam logic [2:0] CHECK_LIMIT = 3'd4;

    state_t     state, next_state;
    logic [7:0] wait_cnt, bit_cnt, bit_num, crc_lo, crc_hi;
    logic [2:0] chk_cnt;
    logic [6:0] crc_reg;
    logic       crc_en_q, crc_flag, end_flag, cplt_seen, got_cplt;

    // One CRC7 step, generator x^7 + x^3 + 1
    function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    assign bit_num  = bit_cnt + 8'd1;
    assign crc_lo   = (des_framesize == LONG_LEN) ? 8'd9 : 8'd1;
    assign crc_hi   = des_framesize - 8'd8;
    assign got_cplt = cplt_seen | des_complete;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        des_enable = (state == RECEIVE);
        resp_valid = (state == DONE);
        case (state)
            IDLE:       if (start) next_state = WAIT_START;
            // A start bit on the final wait cycle takes priority over the timeout
            WAIT_START: begin
                if (!cmd_in)                     next_state = RECEIVE;
                else if (wait_cnt >= WAIT_LAST)  next_state = DONE;
            end
            RECEIVE:    if (bit_cnt >= des_framesize - 8'd1) next_state = CHECK;
            CHECK:      if (got_cplt || chk_cnt >= CHECK_LIMIT) next_state = DONE;
            DONE:       next_state = IDLE;
            default:    next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt      <= '0;
            bit_cnt       <= '0;
            chk_cnt       <= '0;
            crc_reg       <= '0;
            crc_en_q      <= 1'b0;
            crc_flag      <= 1'b0;
            end_flag      <= 1'b0;
            cplt_seen     <= 1'b0;
            des_framesize <= SHORT_LEN;
            resp_data     <= '0;
            timeout_err   <= 1'b0;
            crc_err       <= 1'b0;
            end_err       <= 1'b0;
        end else if (abort) begin
            wait_cnt    <= '0;
            bit_cnt     <= '0;
            chk_cnt     <= '0;
            crc_flag    <= 1'b0;
            end_flag    <= 1'b0;
            cplt_seen   <= 1'b0;
            timeout_err <= 1'b0;
            crc_err     <= 1'b0;
            end_err     <= 1'b0;
        end else begin
            if (des_complete && (state == RECEIVE || state == CHECK)) begin
                resp_data <= des_out;
                cplt_seen <= 1'b1;
            end
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (start) begin
                        des_framesize <= long_resp ? LONG_LEN : SHORT_LEN;
                        crc_en_q      <= crc_check_en;
                        bit_cnt       <= '0;
                        chk_cnt       <= '0;
                        crc_reg       <= '0;
                        crc_flag      <= 1'b0;
                        end_flag      <= 1'b0;
                        cplt_seen     <= 1'b0;
                        timeout_err   <= 1'b0;
                        crc_err       <= 1'b0;
                        end_err       <= 1'b0;
                    end
                end
                WAIT_START: begin
                    if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                    if (!cmd_in) begin
                        bit_cnt <= 8'd1;
                        crc_reg <= (crc_lo == 8'd1) ? crc_step(7'd0, cmd_in) : 7'd0;
                    end else if (wait_cnt >= WAIT_LAST) begin
                        timeout_err <= 1'b1;
                    end
                end
                // Bits inside the CRC window feed the register; the seven after it are
                // compared MSB first by shifting the register out
                RECEIVE: begin
                    chk_cnt <= '0;
                    if (bit_cnt != 8'hFF) bit_cnt <= bit_num;
                    if (bit_num >= crc_lo && bit_num <= crc_hi) begin
                        crc_reg <= crc_step(crc_reg, cmd_in);
                    end else if (bit_num > crc_hi && bit_num < des_framesize) begin
                        if (cmd_in != crc_reg[6]) crc_flag <= 1'b1;
                        crc_reg <= {crc_reg[5:0], 1'b0};
                    end
                    if (bit_num == des_framesize && !cmd_in) end_flag <= 1'b1;
                end
                CHECK: begin
                    if (chk_cnt != 3'd7) chk_cnt <= chk_cnt + 3'd1;
                    if (got_cplt || chk_cnt >= CHECK_LIMIT) begin
                        crc_err <= crc_flag & crc_en_q;
                        end_err <= end_flag | ~got_cplt;
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_resp_ctrl.sv
// Scoreboard bench for cmd_resp_ctrl: the bench plays card and deserializer,
// queues expected responses at start and compares them when resp_valid pulses.
module tb_cmd_resp_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0, long_resp = 1'b0, crc_check_en = 1'b0, abort = 1'b0;
    logic         cmd_in = 1'b1, des_complete = 1'b0;
    logic [135:0] des_out = '0;
    logic         des_enable, busy, resp_valid, timeout_err, crc_err, end_err;
    logic [7:0]   des_framesize;
    logic [135:0] resp_data;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic [135:0] last_data = '0;

    typedef struct {
        logic [135:0] data;
        logic         t, c, e;
        int           cyc;
    } exp_t;
    exp_t sb[$];

    cmd_resp_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .long_resp(long_resp),
        .crc_check_en(crc_check_en), .abort(abort), .cmd_in(cmd_in),
        .des_complete(des_complete), .des_out(des_out), .des_enable(des_enable),
        .des_framesize(des_framesize), .busy(busy), .resp_valid(resp_valid),
        .resp_data(resp_data), .timeout_err(timeout_err), .crc_err(crc_err),
        .end_err(end_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [135:0] got, input logic [135:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference CRC7 over frame bits lo..hi, bit i being f[n-i]
    function automatic logic [6:0] model_crc(input logic [135:0] f, input int n, input int lo, input int hi);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = lo; i <= hi; i++) begin
            fb = f[n-i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [135:0] make_short(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] f;
        f        = '0;
        f[45:40] = idx;
        f[39:8]  = arg;
        f[7:1]   = model_crc(f, 48, 1, 40);
        f[0]     = 1'b1;
        return f;
    endfunction

    function automatic logic [135:0] make_long();
        logic [135:0] f;
        logic [127:0] r;
        r        = {$urandom, $urandom, $urandom, $urandom};
        f        = '0;
        f[133:128] = 6'h3F;
        f[127:8] = r[119:0];
        f[7:1]   = model_crc(f, 136, 9, 128);
        f[0]     = 1'b1;
        return f;
    endfunction

    always @(negedge clk) begin
        if (reset && resp_valid) begin : pop_blk
            exp_t e;
            if (sb.size() == 0) begin
                checkOutput("unexpected_resp", 136'(resp_valid), 136'(0));
            end else begin
                e = sb.pop_front();
                checkOutput("resp_data", resp_data, e.data);
                checkOutput("resp_cycle", 136'(cyc), 136'(e.cyc));
                checkOutput("timeout_err", 136'(timeout_err), 136'(e.t));
                checkOutput("crc_err", 136'(crc_err), 136'(e.c));
                checkOutput("end_err", 136'(end_err), 136'(e.e));
            end
        end
    end

    // cut_kind: 0 none, 1 async reset at cut_bit, 2 abort at cut_bit, 3 stray start at cut_bit
    // dc: des_complete is sampled dc edges after the edge that samples the last bit
    task automatic applyStimulus(input logic [135:0] frame, input logic lng, input logic cen,
                                 input int gap, input int dc, input logic exp_crc,
                                 input logic exp_end, input int cut_kind, input int cut_bit);
        int   n, t0, k, en_bad, w;
        exp_t e;
        n      = lng ? 136 : 48;
        en_bad = 0;
        k      = (dc <= 1) ? 0 : ((dc - 1 > 4) ? 4 : dc - 1);
        start = 1'b1; long_resp = lng; crc_check_en = cen; cmd_in = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
        checkOutput("busy_start", 136'(busy), 136'(1));
        checkOutput("framesize", 136'(des_framesize), 136'(n));
        if (cut_kind != 1 && cut_kind != 2) begin
            e.data = (dc <= 5) ? frame : last_data;
            e.t    = 1'b0;
            e.c    = exp_crc;
            e.e    = exp_end | (dc > 5);
            e.cyc  = t0 + 1 + gap + n + k;
            sb.push_back(e);
        end
        repeat (gap) begin @(posedge clk); #1; end
        for (int i = 1; i <= n; i++) begin
            cmd_in    = frame[n-i];
            start     = (cut_kind == 3 && i == cut_bit);
            long_resp = (cut_kind == 3 && i == cut_bit) ? ~lng : lng;
            abort     = (cut_kind == 2 && i == cut_bit);
            if (dc == 0 && i == n) begin des_out = frame; des_complete = 1'b1; end
            if (cut_kind == 1 && i == cut_bit) begin
                #2 reset = 1'b0;
                #1;
                checkOutput("rst_busy", 136'(busy), 136'(0));
                checkOutput("rst_des_enable", 136'(des_enable), 136'(0));
                checkOutput("rst_resp_valid", 136'(resp_valid), 136'(0));
                checkOutput("rst_resp_data", resp_data, 136'(0));
                checkOutput("rst_flags", 136'({timeout_err, crc_err, end_err}), 136'(0));
                checkOutput("rst_framesize", 136'(des_framesize), 136'(48));
                @(posedge clk); #1;
                reset = 1'b1; cmd_in = 1'b1; last_data = '0;
                return;
            end
            @(negedge clk);
            if (des_enable !== (i >= 2)) en_bad++;
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0; des_complete = 1'b0; long_resp = lng;
            if (cut_kind == 2 && i == cut_bit) begin
                checkOutput("abort_busy", 136'(busy), 136'(0));
                cmd_in = 1'b1;
                return;
            end
        end
        cmd_in = 1'b1;
        checkOutput("des_en_window", 136'(en_bad), 136'(0));
        checkOutput("des_en_after", 136'(des_enable), 136'(0));
        if (dc >= 1) begin
            repeat (dc - 1) begin @(posedge clk); #1; end
            des_out = frame; des_complete = 1'b1;
            @(posedge clk); #1;
            des_complete = 1'b0;
        end
        if (dc <= 5) last_data = frame;
        w = 0;
        while (busy && w < 20) begin @(posedge clk); #1; w++; end
        checkOutput("idle_reached", 136'(busy), 136'(0));
        checkOutput("framesize_held", 136'(des_framesize), 136'(n));
    endtask

    task automatic applyTimeout();
        int   t0, hits;
        exp_t e;
        start = 1'b1; long_resp = 1'b0; crc_check_en = 1'b1; cmd_in = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
        e.data = last_data; e.t = 1'b1; e.c = 1'b0; e.e = 1'b0; e.cyc = t0 + 64;
        sb.push_back(e);
        hits = 0;
        repeat (70) begin
            @(negedge clk);
            if (des_enable) hits++;
            @(posedge clk); #1;
        end
        checkOutput("to_no_enable", 136'(hits), 136'(0));
        checkOutput("to_idle", 136'(busy), 136'(0));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [135:0] fa, fl;
        fa = 136'h400000000095;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 136'(busy), 136'(0));
        checkOutput("reset_des_enable", 136'(des_enable), 136'(0));
        checkOutput("reset_resp_valid", 136'(resp_valid), 136'(0));
        checkOutput("reset_resp_data", resp_data, 136'(0));
        checkOutput("reset_flags", 136'({timeout_err, crc_err, end_err}), 136'(0));
        checkOutput("reset_framesize", 136'(des_framesize), 136'(48));
        reset = 1'b1;
        @(posedge clk); #1;

        applyStimulus(fa, 1'b0, 1'b1, 5, 1, 1'b0, 1'b0, 0, 0);
        applyStimulus(fa ^ (136'h1 << 28), 1'b0, 1'b1, 5, 0, 1'b1, 1'b0, 0, 0);
        applyStimulus(fa ^ (136'h1 << 28), 1'b0, 1'b0, 3, 3, 1'b0, 1'b0, 0, 0);
        applyStimulus(fa ^ 136'h1, 1'b0, 1'b1, 2, 5, 1'b0, 1'b1, 0, 0);
        applyTimeout();
        applyStimulus(make_short(6'h11, $urandom), 1'b0, 1'b1, 63, 1, 1'b0, 1'b0, 0, 0);
        fl = make_long();
        applyStimulus(fl, 1'b1, 1'b1, 2, 1, 1'b0, 1'b0, 0, 0);
        applyStimulus(make_short(6'h0D, $urandom), 1'b0, 1'b1, 1, 7, 1'b0, 1'b0, 0, 0);
        applyStimulus(make_long(), 1'b1, 1'b1, 4, 1, 1'b0, 1'b0, 1, 30);
        applyStimulus(make_short(6'h03, $urandom), 1'b0, 1'b1, 4, 2, 1'b0, 1'b0, 0, 0);
        applyStimulus(make_short(6'h07, $urandom), 1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 3, 20);
        applyStimulus(make_short(6'h08, $urandom), 1'b0, 1'b1, 6, 1, 1'b0, 1'b0, 2, 20);
        repeat (70) @(posedge clk);
        #1;
        checkOutput("sb_empty", 136'(sb.size()), 136'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
